// File: rtl/dac_sample_pacer.sv
// Paced sample FIFO for a DAC: buffers words from the SPI receive stage and
// releases one word every PACE_DIV clocks once primed, flagging overflow/underrun/late.
module dac_sample_pacer #(
    parameter int DEPTH       = 16,
    parameter int PACE_DIV    = 1000,
    parameter int PRIME_LEVEL = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     enable,
    output logic [15:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underrun,
    output logic                     late,
    input  logic                     clear_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(PACE_DIV);

    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);
    localparam logic [CW-1:0] PACE_LAST = CW'(PACE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [CW-1:0]     pace_q, pace_d;
    logic [15:0]       out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              ovf_q, ovf_d;
    logic              udr_q, udr_d;
    logic              late_q, late_d;

    logic full, empty, push, pop, tick;
    logic ovf_evt, udr_evt, late_evt;

    // Events are decoded from registered state only, so in_ready never
    // depends combinationally on a same-cycle pop.
    always_comb begin
        full     = (level_q == FULL_LVL);
        empty    = (level_q == '0);
        push     = in_valid && !full;
        ovf_evt  = in_valid && full;
        tick     = (state_q == RUN) && enable && (pace_q == PACE_LAST);
        pop      = tick && !empty && !out_valid_q;
        udr_evt  = tick && empty && !out_valid_q;
        late_evt = tick && out_valid_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = PRIME;
            end
            PRIME: begin
                if (!enable)                   state_d = IDLE;
                else if (level_q >= PRIME_LVL) state_d = RUN;
            end
            RUN: begin
                if (!enable)      state_d = IDLE;
                else if (udr_evt) state_d = PRIME;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Counter only advances while playing; any other state holds it at zero,
        // which also clears it on every entry into RUN.
        if ((state_q == RUN) && enable)
            pace_d = (pace_q == PACE_LAST) ? '0 : pace_q + CW'(1);
        else
            pace_d = '0;

        out_data_d = pop ? mem_q[rd_ptr_q] : out_data_q;

        if (!enable)
            out_valid_d = 1'b0;
        else if (pop)
            out_valid_d = 1'b1;
        else if (out_valid_q && out_ready)
            out_valid_d = 1'b0;
        else
            out_valid_d = out_valid_q;

        // A flag-setting event outranks a simultaneous clear.
        ovf_d  = ovf_evt  || (ovf_q  && !clear_flags);
        udr_d  = udr_evt  || (udr_q  && !clear_flags);
        late_d = late_evt || (late_q && !clear_flags);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pace_q      <= '0;
            out_data_q  <= 16'h0000;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udr_q       <= 1'b0;
            late_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            pace_q      <= pace_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            udr_q       <= udr_d;
            late_q      <= late_d;
        end
    end

    // Storage array carries no reset; pointers and level define its contents.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign in_ready  = !full;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign underrun  = udr_q;
    assign late      = late_q;

endmodule
